// File: rtl/wb_pkg.sv
// Shared Wishbone definitions: default bus widths and the burst-reader FSM state type.
package wb_pkg;

    localparam int WB_AW = 16;
    localparam int WB_DW = 16;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        DRAIN,
        DONE
    } wb_rd_state_t;

endpackage

// File: rtl/if_wb.sv
// Pipelined Wishbone bus bundle with master and slave views.
interface if_wb
    import wb_pkg::*;
#(
    parameter int AW = WB_AW,
    parameter int DW = WB_DW
);

    logic          cyc;
    logic          stb;
    logic [AW-1:0] adr;
    logic          we;
    logic [DW-1:0] dat_m;
    logic [DW-1:0] dat_s;
    logic          ack;
    logic          stall;

    modport master (output cyc, stb, adr, we, dat_m, input dat_s, ack, stall);
    modport slave  (input cyc, stb, adr, we, dat_m, output dat_s, ack, stall);

endinterface

// File: rtl/fifo_sync.sv
// Synchronous DW x DEPTH FIFO; q is a register holding the head word, never a fall-through path.
module fifo_sync
    import wb_pkg::*;
#(
    parameter int DW    = WB_DW,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [DW-1:0]              din_i,
    output logic [DW-1:0]              q,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [DW-1:0] mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q, rd_nxt;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] q_q, q_d;
    logic          do_push, do_pop;

    assign do_pop  = pop_i && (cnt_q != '0);
    assign do_push = push_i && ((cnt_q != CW'(DEPTH)) || do_pop);
    assign rd_nxt  = rd_ptr_q + PW'(1);

    always_comb begin
        cnt_d = cnt_q;
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
        // The head register follows whichever word becomes oldest after this edge.
        q_d = q_q;
        if (do_push && ((cnt_q == '0) || (do_pop && (cnt_q == CW'(1))))) begin
            q_d = din_i;
        end else if (do_pop && (cnt_q > CW'(1))) begin
            q_d = mem_q[rd_nxt];
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            q_q      <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_q <= rd_nxt;
            cnt_q <= cnt_d;
            q_q   <= q_d;
        end
    end

    assign q     = q_q;
    assign count = cnt_q;
    assign full  = (cnt_q == CW'(DEPTH));
    assign empty = (cnt_q == '0);

endmodule

// File: rtl/wb_burst_reader.sv
// Pipelined Wishbone read master: fetches len words from base and streams them on a valid/ready port.
module wb_burst_reader
    import wb_pkg::*;
#(
    parameter int AW    = WB_AW,
    parameter int DW    = WB_DW,
    parameter int LEN_W = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [AW-1:0]    base,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    output logic             done,
    output logic [DW-1:0]    m_data,
    output logic             m_valid,
    input  logic             m_ready,
    if_wb.master             wb
);

    localparam int OW = $clog2(DEPTH+1);
    localparam logic [OW:0] CREDIT_MAX = DEPTH[OW:0];

    wb_rd_state_t     state_q, state_d;
    logic [AW-1:0]    adr_q, adr_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic [OW-1:0]    out_q, out_d;
    logic [OW-1:0]    fifo_cnt;
    logic             fifo_full, fifo_empty;
    logic             cyc, stb, accept, ack_ok, push, pop;

    assign cyc = (state_q == REQ) || (state_q == WAIT);
    // Words in flight plus words buffered never exceed DEPTH, so every ack has a slot.
    assign stb = (state_q == REQ) && (rem_q != '0)
              && (({1'b0, out_q} + {1'b0, fifo_cnt}) < CREDIT_MAX);

    assign accept  = stb && !wb.stall;
    assign ack_ok  = wb.ack && cyc && (out_q != '0);
    assign m_valid = !fifo_empty;
    assign pop     = m_valid && m_ready;
    assign push    = ack_ok && (!fifo_full || pop);

    always_comb begin
        state_d = state_q;
        adr_d   = adr_q;
        rem_d   = rem_q;
        out_d   = out_q;
        case ({accept, ack_ok})
            2'b10:   out_d = out_q + OW'(1);
            2'b01:   out_d = out_q - OW'(1);
            default: out_d = out_q;
        endcase
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (len != '0) begin
                        state_d = REQ;
                        adr_d   = base;
                        rem_d   = len;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            REQ: begin
                if (accept) begin
                    adr_d = adr_q + AW'(1);
                    rem_d = rem_q - LEN_W'(1);
                    if (rem_q == LEN_W'(1)) state_d = WAIT;
                end
            end
            WAIT:    if (out_q == '0) state_d = DRAIN;
            DRAIN:   if (fifo_empty) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            adr_q   <= '0;
            rem_q   <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            adr_q   <= adr_d;
            rem_q   <= rem_d;
            out_q   <= out_d;
        end
    end

    fifo_sync #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_rsp_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .push_i (push),
        .pop_i  (pop),
        .din_i  (wb.dat_s),
        .q      (m_data),
        .count  (fifo_cnt),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    assign wb.cyc   = cyc;
    assign wb.stb   = stb;
    assign wb.adr   = adr_q;
    assign wb.we    = 1'b0;
    assign wb.dat_m = '0;

    assign busy = (state_q == REQ) || (state_q == WAIT) || (state_q == DRAIN);
    assign done = (state_q == DONE);

endmodule

// File: tb/tb_wb_burst_reader.sv
// Bench for wb_burst_reader: ROM slave with configurable ack latency/stall, stream scoreboard, directed bursts.
module tb_wb_burst_reader;

    localparam int AW    = 16;
    localparam int DW    = 16;
    localparam int LEN_W = 16;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [AW-1:0]    base = '0;
    logic [LEN_W-1:0] len = '0;
    logic             m_ready = 1'b0;
    logic             busy, done, m_valid;
    logic [DW-1:0]    m_data;

    if_wb #(.AW(AW), .DW(DW)) wb_bus ();

    wb_burst_reader #(
        .AW(AW), .DW(DW), .LEN_W(LEN_W), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base(base), .len(len),
        .busy(busy), .done(done), .m_data(m_data), .m_valid(m_valid),
        .m_ready(m_ready), .wb(wb_bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] rom(input logic [AW-1:0] a);
        return a ^ 16'hA5C3;
    endfunction

    // Scoreboard / slave state
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] sq_data[$];
    int            sq_due[$];
    int            lat = 1;
    int            stall_mode = 0;
    logic          force_ack = 1'b0;
    logic          exact = 1'b1;
    logic          in_burst = 1'b0;
    int            b_len = 0, n_acc = 0, n_pop = 0, n_hold = 0;
    int            start_cyc = 0, last_done_lat = -1, done_cnt = 0, cyc_n = 0;
    logic [AW-1:0] exp_adr = '0;
    logic [AW-1:0] acc_log [16];
    int            acc_cyc [16];
    logic [DW-1:0] pop_log [16];
    logic          prev_hold = 1'b0;
    logic [AW-1:0] prev_adr = '0;
    logic          acc;

    // Mid-cycle process: drives the slave side and checks every DUT output.
    initial begin
        forever begin
            @(negedge clk);
            cyc_n++;
            if (!rst_n) begin
                sq_data.delete();
                sq_due.delete();
                exp_q.delete();
                in_burst  = 1'b0;
                prev_hold = 1'b0;
                wb_bus.ack   = 1'b0;
                wb_bus.stall = 1'b0;
                wb_bus.dat_s = '0;
            end else begin
                wb_bus.stall = (stall_mode == 1) && cyc_n[0];
                wb_bus.ack   = 1'b0;
                wb_bus.dat_s = '0;
                if (force_ack) begin
                    wb_bus.ack   = 1'b1;
                    wb_bus.dat_s = 16'hDEAD;
                end else if (sq_due.size() > 0 && sq_due[0] <= cyc_n) begin
                    wb_bus.ack   = 1'b1;
                    wb_bus.dat_s = sq_data.pop_front();
                    void'(sq_due.pop_front());
                end

                chk("we", wb_bus.we, 0);
                chk("dat_m", wb_bus.dat_m, 0);
                if (wb_bus.stb) chk("cyc_with_stb", wb_bus.cyc, 1);
                if (!in_burst) chk("idle_cyc", wb_bus.cyc, 0);
                if (prev_hold) begin
                    chk("stall_stb_held", wb_bus.stb, 1);
                    chk("stall_adr_held", wb_bus.adr, prev_adr);
                end
                acc = wb_bus.cyc && wb_bus.stb && !wb_bus.stall;
                if (acc) begin
                    chk("accept_in_burst", in_burst, 1);
                    chk("adr", wb_bus.adr, exp_adr);
                    acc_log[n_acc % 16] = wb_bus.adr;
                    acc_cyc[n_acc % 16] = cyc_n;
                    exp_adr = exp_adr + AW'(1);
                    n_acc++;
                    sq_data.push_back(rom(wb_bus.adr));
                    sq_due.push_back(cyc_n + lat);
                end
                if (wb_bus.stb && wb_bus.stall && wb_bus.cyc) n_hold++;
                prev_hold = wb_bus.stb && wb_bus.stall && wb_bus.cyc;
                prev_adr  = wb_bus.adr;
                if (in_burst) begin
                    chk("credit", (n_acc - n_pop) <= DEPTH, 1);
                    chk("accepts_le_len", n_acc <= b_len, 1);
                    if (b_len == 0) chk("len0_no_cyc", wb_bus.cyc, 0);
                end

                if (m_valid) begin
                    if (exp_q.size() == 0) begin
                        chk("m_valid_spurious", m_valid, 0);
                    end else begin
                        chk("m_data", m_data, exp_q[0]);
                        if (m_ready) begin
                            pop_log[n_pop % 16] = m_data;
                            n_pop++;
                            void'(exp_q.pop_front());
                        end
                    end
                end

                chk("busy", busy, in_burst && (b_len != 0) && !done);
                if (done) begin
                    chk("done_in_burst", in_burst, 1);
                    if (in_burst) begin
                        chk("done_all_accepted", n_acc, b_len);
                        chk("done_all_delivered", exp_q.size(), 0);
                        last_done_lat = cyc_n - start_cyc;
                        if (exact) chk("done_latency", last_done_lat, (b_len == 0) ? 1 : b_len + 4);
                        in_burst = 1'b0;
                        done_cnt++;
                    end
                end

                if (start && !busy && !done) begin
                    in_burst  = 1'b1;
                    b_len     = int'(len);
                    n_acc     = 0;
                    n_pop     = 0;
                    n_hold    = 0;
                    start_cyc = cyc_n;
                    exp_adr   = base;
                    exp_q.delete();
                    for (int i = 0; i < int'(len); i++) exp_q.push_back(rom(base + AW'(i)));
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic go(input logic [AW-1:0] b, input logic [LEN_W-1:0] l);
        base  = b;
        len   = l;
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int bound);
        int c0 = done_cnt;
        int i = 0;
        while (done_cnt == c0 && i < bound) begin
            tick(1);
            i++;
        end
        chk({name, "_done_seen"}, done_cnt != c0, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    int dc;

    initial begin
        wb_bus.ack   = 1'b0;
        wb_bus.stall = 1'b0;
        wb_bus.dat_s = '0;
        m_ready = 1'b1;
        tick(3);
        chk("rst_cyc", wb_bus.cyc, 0);
        chk("rst_stb", wb_bus.stb, 0);
        chk("rst_adr", wb_bus.adr, 0);
        chk("rst_we", wb_bus.we, 0);
        chk("rst_dat_m", wb_bus.dat_m, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_data", m_data, 0);
        rst_n = 1'b1;
        tick(2);

        // Back-to-back ROM burst at full rate
        lat = 1; stall_mode = 0; exact = 1'b1; m_ready = 1'b1;
        go(16'h0010, 8);
        wait_done("t1", 40);
        chk("t1_done_lat", last_done_lat, 12);
        chk("t1_acc", n_acc, 8);
        chk("t1_first_word", pop_log[0], 16'hA5D3);
        chk("t1_last_word", pop_log[7], 16'hA5D4);
        chk("t1_adr_last", acc_log[7], 16'h0017);
        chk("t1_adr_consecutive", acc_cyc[7] - acc_cyc[0], 7);

        // Slave stalls every other cycle
        stall_mode = 1; exact = 1'b0;
        go(16'h0200, 5);
        wait_done("t2", 60);
        stall_mode = 0;
        chk("t2_acc", n_acc, 5);
        chk("t2_pop", n_pop, 5);
        chk("t2_last_word", pop_log[4], 16'hA7C7);
        chk("t2_stall_seen", n_hold > 0, 1);

        // Downstream blocked: credit limit must throttle requests
        m_ready = 1'b0;
        go(16'h0300, 10);
        tick(20);
        chk("t3_acc_blocked", n_acc, 4);
        chk("t3_stb_low", wb_bus.stb, 0);
        chk("t3_m_valid", m_valid, 1);
        m_ready = 1'b1;
        wait_done("t3", 60);
        chk("t3_pop", n_pop, 10);
        chk("t3_last_word", pop_log[9], 16'hA6CA);

        // Address wrap
        exact = 1'b1;
        go(16'hFFFE, 4);
        wait_done("t4", 40);
        chk("t4_adr0", acc_log[0], 16'hFFFE);
        chk("t4_adr1", acc_log[1], 16'hFFFF);
        chk("t4_adr2", acc_log[2], 16'h0000);
        chk("t4_adr3", acc_log[3], 16'h0001);
        chk("t4_word2", pop_log[2], 16'hA5C3);

        // Zero-length burst, then start while busy
        go(16'h1234, 0);
        wait_done("t5a", 10);
        chk("t5_len0_lat", last_done_lat, 1);
        go(16'h0400, 3);
        tick(1);
        chk("t5_busy", busy, 1);
        go(16'h0500, 5);
        wait_done("t5b", 40);
        chk("t5_pop", n_pop, 3);
        dc = done_cnt;
        tick(10);
        chk("t5_second_ignored_cyc", wb_bus.cyc, 0);
        chk("t5_second_ignored_done", done_cnt, dc);

        // Asynchronous reset with two requests outstanding
        lat = 3; m_ready = 1'b0; exact = 1'b0;
        go(16'h0600, 8);
        tick(5);
        chk("t6_pre_cyc", wb_bus.cyc, 1);
        chk("t6_pre_m_valid", m_valid, 1);
        dc = done_cnt;
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_cyc", wb_bus.cyc, 0);
        chk("t6_async_stb", wb_bus.stb, 0);
        chk("t6_async_m_valid", m_valid, 0);
        chk("t6_async_busy", busy, 0);
        tick(2);
        rst_n = 1'b1;
        m_ready = 1'b1;
        lat = 1;
        tick(1);
        force_ack = 1'b1;
        tick(1);
        force_ack = 1'b0;
        tick(4);
        chk("t6_no_done", done_cnt, dc);
        chk("t6_stray_ignored", m_valid, 0);

        // Stray ack during cyc with nothing outstanding
        exact = 1'b1;
        go(16'h0700, 3);
        force_ack = 1'b1;
        tick(1);
        force_ack = 1'b0;
        wait_done("t7", 40);
        chk("t7_pop", n_pop, 3);
        chk("t7_first_word", pop_log[0], 16'hA2C3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_burst_reader.md
# wb_burst_reader

Pipelined Wishbone read master that fetches a contiguous block of words (e.g. from the boot ROM) and streams them out on a valid/ready port. It is the initiator counterpart of the Wishbone slaves on the J1 system bus. It issues classic pipelined read cycles, honours `stall`, collects `ack` data into a small response FIFO, and throttles requests so that no acknowledged word can ever be dropped.

## Interface
Parameters:
- `AW`, 16: word address width
- `DW`, 16: data width
- `LEN_W`, 16: burst length counter width
- `DEPTH`, 4: response FIFO depth (power of two, ≥2)

Ports:
- `clk` in 1: single clock. The `wb` interface is driven from this clock.
- `rst_n` in 1: reset, asynchronous, active-low
- `start` in 1: request a burst; sampled only while idle
- `base` in AW: first word address, sampled with `start`
- `len` in LEN_W: number of words, sampled with `start`
- `busy` out 1: burst in progress
- `done` out 1: one-cycle pulse at burst completion
- `m_data` out DW: streamed read data
- `m_valid` out 1: `m_data` valid
- `m_ready` in 1: downstream accepts the word
- `wb` `if_wb.master`: drives `cyc`, `stb`, `adr`, `we`, `dat_m`; samples `dat_s`, `ack`, `stall`

## Operation
- `we`=0 and `dat_m`=0 always (read-only master).
- FSM states:
  - IDLE:
    - `start` with `len`≠0 → REQ. Latch `adr`←`base`, `remaining`←`len`.
    - `start` with `len`=0 → DONE; no bus activity.
  - REQ: `cyc`=1. `stb`=1 whenever `remaining`≠0 and `outstanding + fifo_count < DEPTH` (credit rule).
    - Request accepted on a cycle with `stb & ~stall`: `adr`++ (wraps modulo 2^AW), `remaining`--, `outstanding`++.
    - `remaining` reaches 0 → WAIT.
  - WAIT: `cyc`=1, `stb`=0. Transition when `outstanding`=0 → DRAIN, with `cyc` dropping the same edge.
  - DRAIN: bus idle. Transition when FIFO empty → DONE.
  - DONE: `done`=1 for one cycle → IDLE.
- `stb` and `adr` are held stable while `stall`=1.
- `ack` while `cyc`=1 and `outstanding`≠0: push `dat_s` into the FIFO and decrement `outstanding`.
  - Accept and ack in the same cycle: net `outstanding` change is 0.
- `ack` with `outstanding`=0 or `cyc`=0 is ignored: no push, no count change.
- `busy` = state ≠ IDLE and state ≠ DONE.
- `start` while `busy` is ignored.
- FIFO pop on `m_valid & m_ready`. A simultaneous push and pop is legal when the FIFO is full. The credit rule guarantees no push occurs into a full FIFO without a pop.
- Counters:
  - `outstanding` is `$clog2(DEPTH+1)` bits wide.
  - `remaining` is LEN_W bits wide; `len`=2^LEN_W−1 must work.

## Timing
- Reset values: `cyc`=0, `stb`=0, `adr`=0, `we`=0, `dat_m`=0, `busy`=0, `done`=0, `m_valid`=0, `m_data`=0; FSM in IDLE; all counters 0.
- Async assertion of `rst_n` mid-burst:
  - `cyc`/`stb` drop immediately and the FIFO is flushed.
  - No `done` pulse is generated.
- `start` accepted at edge 0 → first `stb` during cycle 1.
- Response path: `ack` at edge n → word on `m_data`/`m_valid` during cycle n+1 (registered FIFO output, no fall-through).
- Throughput with a zero-stall, 1-cycle-ack slave and `m_ready`=1: one word per cycle for DEPTH≥4.
  - Burst of L words: `done` pulses L+4 cycles after `start` is accepted.
- `len`=0: `done` pulses in cycle 1 and `busy` stays 0.

## Structure
- Shared package `wb_pkg` holds:
  - the FSM state enum type (`wb_rd_state_t`: IDLE, REQ, WAIT, DRAIN, DONE);
  - the default `AW`/`DW` localparams shared with the slaves.
- Sub-module `fifo_sync`: parameterised DW×DEPTH synchronous FIFO with async active-low reset.
  - Outputs: `count`, `full`, `empty`, and registered `q`.
  - Reused by other bus bridges.
- Remaining logic is a single module: FSM, address counter, `remaining`/`outstanding` counters, credit logic.

## Test plan
- ROM model (ack 1 cycle after accept, no stall), `base`=0x0010, `len`=8, `m_ready`=1 → `adr` 0x0010..0x0017 on consecutive cycles, 8 words in order, `done` 12 cycles after `start`.
- Slave stalls every other cycle, `len`=5 → `adr`/`stb` held during each stall, exactly 5 accepts, 5 words out in order, no duplicates.
- `m_ready`=0 for 20 cycles, `len`=10, DEPTH=4 → `outstanding + fifo_count` never exceeds 4, `stb` deasserts. After `m_ready`=1, all 10 words are delivered in order.
- `base`=0xFFFE, `len`=4 → addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- `len`=0 → no `cyc`, `busy`=0, `done` pulse in cycle 1. Then assert `start` while busy on a `len`=3 burst → second `start` ignored, only 3 words out.
- `rst_n` low mid-burst with 2 words outstanding → `cyc`/`stb`/`m_valid` drop asynchronously, no `done`. A stray `ack` after release is ignored.
